// File: rtl/sha_512_pad_if.sv
// Padder-side bundle: byte-granular message stream in, block/start/digest towards the SHA-512 core.
interface sha_512_pad_if;
   logic [1:0]    Mode;
   logic [63:0]   In_Data;
   logic [3:0]    In_Bytes;
   logic          In_Last;
   logic          In_Valid;
   logic          In_Ready;
   logic [1023:0] Data;
   logic [127:0]  Index;
   logic [1:0]    Operation;
   logic          Enable;
   logic          Core_Ready;
   logic [511:0]  Core_Hash;
   logic [511:0]  Hash;
   logic          Hash_Valid;

   modport master (
      output Mode, In_Data, In_Bytes, In_Last, In_Valid, Core_Ready, Core_Hash,
      input  In_Ready, Data, Index, Operation, Enable, Hash, Hash_Valid
   );
   modport slave (
      input  Mode, In_Data, In_Bytes, In_Last, In_Valid, Core_Ready, Core_Hash,
      output In_Ready, Data, Index, Operation, Enable, Hash, Hash_Valid
   );
endinterface

// File: rtl/sha_512_pad.sv
// SHA-512 message padder: packs the word stream into 1024-bit blocks, appends marker/zero fill/bit length,
// hands each block to the core and forwards the final digest.
module sha_512_pad (
   input logic          clk,
   input logic          rst,
   sha_512_pad_if.slave bus
);
   typedef enum logic [1:0] {FILL, PAD, SEND, WAIT} state_t;

   state_t            state, state_nxt;
   logic [15:0][63:0] blk;
   logic [3:0]        w;
   logic [127:0]      len, cnt, idx;
   logic [1:0]        op;
   logic [511:0]      hash;
   logic              mark_done, msg_done, fin, started, rdy, hv, enable;
   logic              xfer, partial;
   logic [63:0]       word;

   assign xfer    = (state == FILL) && rdy && bus.In_Valid;
   assign partial = bus.In_Last && (bus.In_Bytes < 4'd8);

   // Short last word: keep the valid bytes, drop the 0x80 marker right after them, zero the rest.
   always_comb begin
      word = bus.In_Data;
      if (partial)
         for (int b = 0; b < 8; b++)
            if (b == int'(bus.In_Bytes))     word[63-8*b -: 8] = 8'h80;
            else if (b > int'(bus.In_Bytes)) word[63-8*b -: 8] = 8'h00;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= FILL;
      else      state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         FILL: if (xfer) begin
                  if (w == 4'd15)       state_nxt = SEND;
                  else if (bus.In_Last) state_nxt = PAD;
               end
         PAD:  if ((mark_done && w == 4'd14) || w == 4'd15) state_nxt = SEND;
         SEND: state_nxt = WAIT;
         WAIT: if (bus.Core_Ready) state_nxt = (fin || !msg_done) ? FILL : PAD;
         default: state_nxt = FILL;
      endcase
   end

   always_comb begin
      enable = 1'b0;
      if (state == SEND) enable = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blk       <= '0;
         w         <= '0;
         len       <= '0;
         cnt       <= 128'd1;
         idx       <= '0;
         op        <= '0;
         hash      <= '0;
         mark_done <= 1'b0;
         msg_done  <= 1'b0;
         fin       <= 1'b0;
         started   <= 1'b0;
         rdy       <= 1'b0;
         hv        <= 1'b0;
      end else begin
         rdy <= (state_nxt == FILL);
         hv  <= 1'b0;
         // Index is captured on the way into SEND so it is already valid alongside Enable.
         if (state_nxt == SEND) idx <= cnt;
         case (state)
            FILL: if (xfer) begin
               blk[w] <= word;
               len    <= len + 128'({bus.In_Bytes, 3'b000});
               w      <= w + 4'd1;
               if (!started) begin
                  op      <= bus.Mode;
                  started <= 1'b1;
               end
               if (bus.In_Last) begin
                  msg_done  <= 1'b1;
                  mark_done <= partial;
               end
            end
            PAD: if (mark_done && w == 4'd14) begin
               blk[14] <= len[127:64];
               blk[15] <= len[63:0];
               fin     <= 1'b1;
            end else begin
               blk[w]    <= mark_done ? 64'd0 : {8'h80, 56'd0};
               mark_done <= 1'b1;
               w         <= w + 4'd1;
            end
            WAIT: if (bus.Core_Ready) begin
               blk <= '0;
               w   <= '0;
               if (fin) begin
                  hash      <= bus.Core_Hash;
                  hv        <= 1'b1;
                  len       <= '0;
                  cnt       <= 128'd1;
                  mark_done <= 1'b0;
                  msg_done  <= 1'b0;
                  fin       <= 1'b0;
                  started   <= 1'b0;
               end else begin
                  cnt <= cnt + 128'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.In_Ready   = rdy;
   assign bus.Data       = blk;
   assign bus.Index      = idx;
   assign bus.Operation  = op;
   assign bus.Enable     = enable;
   assign bus.Hash       = hash;
   assign bus.Hash_Valid = hv;
endmodule

// File: tb/tb_sha_512_pad.sv
// Random and directed messages against a byte-queue FIPS 180-4 padding model, with a stub core returning random digests.
module tb_sha_512_pad;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sha_512_pad_if bus ();
   sha_512_pad dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Stub core: latches the block on Enable, answers after core_delay cycles, and sometimes pulses Core_Ready while idle.
   int            core_delay = 2;
   int            dly;
   logic          busy, hold_ok, moved;
   logic [1023:0] cap_data;
   logic [127:0]  cap_idx;
   logic [1:0]    cap_op;
   logic [511:0]  pend_hash, last_hash;
   logic [1023:0] got_data[$];
   logic [127:0]  got_idx[$];
   logic [1:0]    got_op[$];
   bit            got_ok[$];

   assign moved = (bus.Data !== cap_data) || (bus.Index !== cap_idx) ||
                  (bus.Operation !== cap_op) || (bus.In_Ready !== 1'b0);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy           <= 1'b0;
         dly            <= 0;
         hold_ok        <= 1'b1;
         bus.Core_Ready <= 1'b0;
         bus.Core_Hash  <= '0;
         pend_hash      <= rnd512();
      end else begin
         bus.Core_Ready <= 1'b0;
         if (bus.Enable === 1'b1) begin
            busy     <= 1'b1;
            dly      <= core_delay;
            hold_ok  <= 1'b1;
            cap_data <= bus.Data;
            cap_idx  <= bus.Index;
            cap_op   <= bus.Operation;
         end else if (busy) begin
            if (moved) hold_ok <= 1'b0;
            if (dly == 0) begin
               busy           <= 1'b0;
               bus.Core_Ready <= 1'b1;
               bus.Core_Hash  <= pend_hash;
               last_hash      <= pend_hash;
               pend_hash      <= rnd512();
               got_data.push_back(cap_data);
               got_idx.push_back(cap_idx);
               got_op.push_back(cap_op);
               got_ok.push_back(hold_ok && !moved);
            end else begin
               dly <= dly - 1;
            end
         end else if ($urandom_range(7) == 0) begin
            bus.Core_Ready <= 1'b1;
            bus.Core_Hash  <= rnd512();
         end
      end
   end

   int           en_cnt = 0;
   int           hv_cnt = 0;
   logic [511:0] hv_hash;
   always @(posedge clk) if (rst === 1'b1 && bus.Enable === 1'b1) en_cnt <= en_cnt + 1;
   always @(negedge clk) if (bus.Hash_Valid === 1'b1) begin
      hv_cnt  <= hv_cnt + 1;
      hv_hash <= bus.Hash;
   end

   task automatic chk_zero(input string t);
      chk({t, "_in_ready"},   bus.In_Ready, 0);
      chk({t, "_data_lo"},    bus.Data[511:0], 0);
      chk({t, "_data_hi"},    bus.Data[1023:512], 0);
      chk({t, "_index"},      bus.Index, 0);
      chk({t, "_operation"},  bus.Operation, 0);
      chk({t, "_enable"},     bus.Enable, 0);
      chk({t, "_hash"},       bus.Hash, 0);
      chk({t, "_hash_valid"}, bus.Hash_Valid, 0);
   endtask

   // Feed a message as words; bytes past In_Bytes carry garbage, Mode is scrambled after the first word.
   task automatic feed(input logic [1:0] mode, input logic [7:0] msg[$], input bit extra);
      int nw, nb, n;
      logic [63:0] wd;
      nw = (msg.size() + 7) / 8;
      if (extra || nw == 0) nw++;
      for (int k = 0; k < nw; k++) begin
         if ($urandom_range(3) == 0) begin
            bus.In_Valid = 1'b0;
            bus.In_Data  = {$urandom, $urandom};
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         nb = msg.size() - 8*k;
         if (nb > 8) nb = 8;
         for (int b = 0; b < 8; b++)
            if (b < nb) wd[63-8*b -: 8] = msg[8*k + b];
            else        wd[63-8*b -: 8] = 8'($urandom);
         bus.In_Data  = wd;
         bus.In_Bytes = 4'(nb);
         bus.In_Last  = (k == nw - 1);
         bus.Mode     = (k == 0) ? mode : 2'($urandom);
         bus.In_Valid = 1'b1;
         n = 0;
         while (bus.In_Ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
         end
         if (n == 2000) begin
            chk("in_ready_timeout", bus.In_Ready, 1);
            bus.In_Valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      bus.In_Valid = 1'b0;
      bus.In_Last  = 1'b0;
   endtask

   task automatic run_msg(input logic [1:0] mode, input logic [7:0] msg[$], input bit extra);
      logic [7:0]    pad[$];
      logic [127:0]  bits;
      logic [63:0]   ew;
      logic [1023:0] blkv;
      int nblk, b0, e0, h0, n;
      pad = msg;
      pad.push_back(8'h80);
      while (pad.size() % 128 != 112) pad.push_back(8'h00);
      bits = 128'(msg.size()) << 3;
      for (int i = 15; i >= 0; i--) pad.push_back(bits[8*i +: 8]);
      nblk = pad.size() / 128;
      b0 = got_data.size();
      e0 = en_cnt;
      h0 = hv_cnt;
      feed(mode, msg, extra);
      n = 0;
      while (hv_cnt == h0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk("blocks",    got_data.size() - b0, nblk);
      chk("enables",   en_cnt - e0, nblk);
      chk("hv_pulses", hv_cnt - h0, 1);
      chk("hash",      hv_hash, last_hash);
      for (int j = 0; j < nblk && b0 + j < got_data.size(); j++) begin
         blkv = got_data[b0 + j];
         chk("index", got_idx[b0 + j], j + 1);
         chk("op",    got_op[b0 + j], mode);
         chk("hold",  got_ok[b0 + j], 1);
         for (int i = 0; i < 16; i++) begin
            for (int b = 0; b < 8; b++) ew[63-8*b -: 8] = pad[128*j + 8*i + b];
            chk($sformatf("blk%0d_slot%0d", j, i), blkv[64*i +: 64], ew);
         end
      end
   endtask

   initial begin
      logic [7:0] q[$];
      int len, n;
      bit ex;
      int dl[6] = '{8, 119, 120, 127, 128, 240};
      rst = 1'b0;
      bus.In_Valid = 1'b0;
      bus.In_Data  = '0;
      bus.In_Bytes = '0;
      bus.In_Last  = 1'b0;
      bus.Mode     = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b1;
      #1 chk("rdy_before_edge", bus.In_Ready, 0);
      @(negedge clk);
      chk("rdy_after_rst", bus.In_Ready, 1);

      q = {};
      run_msg(2'd3, q, 1'b0);
      q = {8'h61, 8'h62, 8'h63};
      run_msg(2'd3, q, 1'b0);
      q = {};
      repeat (112) q.push_back(8'($urandom));
      run_msg(2'd3, q, 1'b0);
      q = {};
      repeat (111) q.push_back(8'($urandom));
      run_msg(2'd1, q, 1'b0);

      core_delay = 100;
      q = {};
      repeat (200) q.push_back(8'($urandom));
      run_msg(2'd2, q, 1'b0);
      core_delay = 2;

      // Reset while the core is working on a block.
      q = {8'h61, 8'h62, 8'h63};
      feed(2'd3, q, 1'b0);
      n = 0;
      while (!busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_wait", busy, 1);
      #2 rst = 1'b0;
      #1 chk_zero("async_rst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      q = {8'h61, 8'h62, 8'h63};
      run_msg(2'd0, q, 1'b0);

      foreach (dl[k]) begin
         q = {};
         repeat (dl[k]) q.push_back(8'($urandom));
         run_msg(2'($urandom), q, (dl[k] % 8 == 0) && (k % 2 == 0));
      end

      repeat (24) begin
         len = $urandom_range(0, 300);
         q = {};
         repeat (len) q.push_back(8'($urandom));
         ex = (len > 0) && (len % 8 == 0) && ($urandom_range(1) == 1);
         core_delay = $urandom_range(0, 5);
         run_msg(2'($urandom), q, ex);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
